// File: rtl/slow_tick_timer.sv
// Round timer driven by a toggling slow clock: synchronises slow_in, turns each toggle into a
// one-cycle tick and counts ticks down through IDLE/RUN/PAUSE/EXPIRED. Define STALL_DETECT_EN for the stall flag.
module slow_tick_timer #(
   parameter int          SYNC_STAGES = 2,
   parameter int          W           = 8,
   parameter logic [31:0] ROUND_TICKS = 32'd10,
   parameter logic [31:0] TIMEOUT     = 32'd1_600_000_000
) (
   input  logic         cin,
   input  logic         rst_n,
   input  logic         slow_in,
   input  logic         start,
   input  logic         pause,
   input  logic         clear,
   output logic         tick,
   output logic [W-1:0] remaining,
   output logic         running,
   output logic         expired,
   output logic         done,
   output logic         stall,
   output logic [1:0]   dbg_state_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED} state_e;

   localparam int          PRIME_N    = SYNC_STAGES + 1;
   localparam int          PW         = $clog2(PRIME_N + 1);
   localparam logic [W-1:0] ROUND_LOAD = ROUND_TICKS[W-1:0];

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [PW-1:0]          prime_q;
   logic                   primed;
   logic                   edge_det;
   logic                   tick_q;

   state_e                 state_q, state_d;
   logic [W-1:0]           rem_q, rem_d;
   logic                   running_q, running_d;
   logic                   done_q, done_d;
   logic                   expired_q, expired_d;

   // Edges are suppressed until the chain holds real samples, so a level already high at release is not a toggle.
   assign primed   = (prime_q == PW'(PRIME_N));
   assign edge_det = primed & (sync_q[SYNC_STAGES-1] ^ prev_q);

   always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         prime_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         if (!primed) begin
            prime_q <= prime_q + PW'(1);
         end
         tick_q <= edge_det;
      end
   end

   always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         running_q <= running_d;
         done_q    <= done_d;
         expired_q <= expired_d;
      end
   end

   // Priority: clear, then start, then pause, then the tick seen this cycle.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (clear) begin
         state_d = ST_IDLE;
         rem_d   = '0;
      end else if (start) begin
         state_d = ST_RUN;
         rem_d   = ROUND_LOAD;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSE;
               end else if (tick_q) begin
                  if (rem_q > W'(1)) begin
                     rem_d = rem_q - W'(1);
                  end else begin
                     rem_d   = '0;
                     state_d = ST_EXPIRED;
                  end
               end
            end
            ST_PAUSE: begin
               if (!pause) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_comb begin
      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_EXPIRED);
      expired_d = (state_q == ST_RUN) && (state_d == ST_EXPIRED);
   end

`ifdef STALL_DETECT_EN
   logic [31:0] idle_q;

   always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
      end else if (edge_det) begin
         idle_q <= '0;
      end else if (primed && (idle_q != TIMEOUT - 32'd1)) begin
         idle_q <= idle_q + 32'd1;
      end
   end

   assign stall = (idle_q == TIMEOUT - 32'd1);
`else
   assign stall = 1'b0;
`endif

   assign tick        = tick_q;
   assign remaining   = rem_q;
   assign running     = running_q;
   assign done        = done_q;
   assign expired     = expired_q;
   assign dbg_state_o = state_q;

endmodule
